operand_buffer: RTL and testbench

Parametrised operand store for the TPU datapath. Accepts one streamed frame over a valid/ready handshake: an N×N weight matrix followed by an N×N input matrix, one element per beat. Presents both matrices as flat registered buses to the systolic array, with a valid/ack handshake. Generalises the fixed 2×2, 8-bit, address-driven operand memory to arbitrary N and element width, with auto-sequenced loading and frame completion tracking. Optional ping-pong banking lets the next frame load while the array consumes the current one.

---
 rtl/operand_buffer.sv | 166 ++++++++++++++++
 tb/tb_operand_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_buffer.sv
// operand_buffer
//   Operand store for the systolic array. One frame is streamed in over a
//   valid/ready handshake: N*N weight elements then N*N input elements,
//   row-major, one element per beat. The complete frame is presented on two
//   flat registered buses with a valid/ack handshake.
//
//   Build option: OPERAND_BUFFER_PINGPONG_EN
//     undefined - one bank; the presented buses are the bank itself.
//     defined   - two banks; the next frame loads while the current one is
//                 presented.
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     in_valid   producer has an element on in_data
//     in_ready   buffer can accept an element (0 while rst=1)
//     in_data    element value
//     flush      abandon the partially loaded frame (load_idx <- 0)
//     out_valid  a complete frame is presented on weights/inputs
//     out_ack    consumer releases the presented frame
//     weights    element k = r*N+c at [k*DW +: DW]
//     inputs     same layout as weights
//     load_idx   index of the next element to be written
module operand_buffer #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ack,
  output logic [N*N*DW-1:0]            weights,
  output logic [N*N*DW-1:0]            inputs,
  output logic [$clog2(2*N*N)-1:0]     load_idx
);

  localparam int NN = N * N;
  localparam int LW = $clog2(2 * NN);
  localparam logic [LW-1:0] LAST_IDX = LW'(2 * NN - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } bank_st_t;

  logic              beat;
  logic              last_beat;
  logic              ack;
  logic [31:0]       widx;
  logic [LW-1:0]     load_idx_nxt;
  logic [NN*DW-1:0]  w_bank;
  logic [NN*DW-1:0]  i_bank;
  logic [NN*DW-1:0]  w_nxt;
  logic [NN*DW-1:0]  i_nxt;

  // flush wins over a concurrent beat
  assign beat      = in_valid && in_ready && !flush;
  assign last_beat = beat && (load_idx == LAST_IDX);
  assign ack       = out_ack && out_valid;
  assign widx      = 32'(load_idx);

  always_comb begin
    load_idx_nxt = load_idx;
    if (flush) begin
      load_idx_nxt = '0;
    end else if (beat) begin
      load_idx_nxt = last_beat ? '0 : load_idx + 1'b1;
    end
  end

  // Filling-bank contents after this edge's beat (if any)
  always_comb begin
    w_nxt = w_bank;
    i_nxt = i_bank;
    if (beat) begin
      if (widx < 32'(NN)) begin
        w_nxt[widx*DW +: DW] = in_data;
      end else begin
        i_nxt[(widx - 32'(NN))*DW +: DW] = in_data;
      end
    end
  end

`ifdef OPERAND_BUFFER_PINGPONG_EN

  // The presented bank is held in the output registers and the filling bank
  // in sh_w/sh_i; a swap copies the filling bank (including a last beat on
  // the same edge) into the output registers. A filling bank is always fully
  // rewritten before it can be presented, so this matches role swapping.
  bank_st_t          pres_st;
  bank_st_t          fill_st;
  logic [NN*DW-1:0]  sh_w;
  logic [NN*DW-1:0]  sh_i;
  logic              fill_full_nxt;
  logic              swap;

  assign w_bank        = sh_w;
  assign i_bank        = sh_i;
  assign in_ready      = !rst && (fill_st == FILL);
  assign out_valid     = (pres_st == FULL);
  assign fill_full_nxt = (fill_st == FULL) || last_beat;
  assign swap          = fill_full_nxt && (!out_valid || ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_w     <= '0;
      sh_i     <= '0;
      weights  <= '0;
      inputs   <= '0;
      load_idx <= '0;
      pres_st  <= FILL;
      fill_st  <= FILL;
    end else begin
      sh_w     <= w_nxt;
      sh_i     <= i_nxt;
      load_idx <= load_idx_nxt;
      if (swap) begin
        weights <= w_nxt;
        inputs  <= i_nxt;
        pres_st <= FULL;
        fill_st <= FILL;
      end else begin
        if (ack) begin
          pres_st <= FILL;
        end
        if (last_beat) begin
          fill_st <= FULL;
        end
      end
    end
  end

`else

  bank_st_t st;

  assign w_bank    = weights;
  assign i_bank    = inputs;
  assign in_ready  = !rst && (st == FILL);
  assign out_valid = (st == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      weights  <= '0;
      inputs   <= '0;
      load_idx <= '0;
      st       <= FILL;
    end else begin
      weights  <= w_nxt;
      inputs   <= i_nxt;
      load_idx <= load_idx_nxt;
      if (last_beat) begin
        st <= FULL;
      end else if (ack) begin
        st <= FILL;
      end
    end
  end

`endif

endmodule

// File: tb/tb_operand_buffer.sv
module tb_operand_buffer;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int NN = N * N;
  localparam int LW = $clog2(2 * NN);
`ifdef OPERAND_BUFFER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ack;
  logic [NN*DW-1:0]  weights;
  logic [NN*DW-1:0]  inputs;
  logic [LW-1:0]     load_idx;

  operand_buffer #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .weights   (weights),
    .inputs    (inputs),
    .load_idx  (load_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is the ordered list of accepted elements; the buffer holds up to
  // CAP complete, unreleased frames.
  typedef struct packed {
    logic [NN*DW-1:0] w;
    logic [NN*DW-1:0] i;
  } frame_t;

  logic [DW-1:0] img [2*NN];
  int            m_idx  = 0;
  int            m_held = 0;
  frame_t        exp_q[$];

  function automatic logic [NN*DW-1:0] pack(input int base);
    logic [NN*DW-1:0] v;
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = img[base + k];
    return v;
  endfunction

  initial for (int k = 0; k < 2*NN; k++) img[k] = '0;

  always @(posedge clk) begin
    bit acc;
    bit ackd;
    frame_t f;
    acc  = !rst && in_valid && !flush && (m_held < CAP);
    ackd = !rst && out_ack && (m_held > 0);
    if (rst) begin
      for (int k = 0; k < 2*NN; k++) img[k] = '0;
      m_idx  = 0;
      m_held = 0;
      exp_q.delete();
    end else begin
      if (flush) begin
        m_idx = 0;
      end else if (acc) begin
        img[m_idx] = in_data;
        m_idx++;
        if (m_idx == 2*NN) begin
          m_idx = 0;
          f.w = pack(0);
          f.i = pack(NN);
          exp_q.push_back(f);
          m_held++;
        end
      end
      if (ackd) m_held--;
    end
  end

  // ---------------- monitor ----------------
  bit     prev_ov  = 1'b0;
  bit     prev_ack = 1'b0;
  bit     prev_rst = 1'b1;
  frame_t shown    = '0;

  always @(negedge clk) begin
    frame_t f;
    if (prev_rst) shown = '0;
    chk("in_ready", 64'(in_ready), 64'(!rst && (m_held < CAP)));
    chk("out_valid", 64'(out_valid), 64'(m_held > 0));
    chk("load_idx", 64'(load_idx), 64'(m_idx));
    if (out_valid && (!prev_ov || prev_ack)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 64'(1), 64'(0));
      end else begin
        f = exp_q.pop_front();
        shown = f;
        chk("frame_weights", 64'(weights), 64'(f.w));
        chk("frame_inputs", 64'(inputs), 64'(f.i));
      end
    end
`ifdef OPERAND_BUFFER_PINGPONG_EN
    chk("shown_weights", 64'(weights), 64'(shown.w));
    chk("shown_inputs", 64'(inputs), 64'(shown.i));
`else
    chk("live_weights", 64'(weights), 64'(pack(0)));
    chk("live_inputs", 64'(inputs), 64'(pack(NN)));
`endif
    prev_ov  = out_valid;
    prev_ack = out_ack && out_valid;
    prev_rst = rst;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one element and returns just after the edge that accepts it.
  task automatic send(input logic [DW-1:0] d);
    bit rdy;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_run(input logic [DW-1:0] first, input logic [DW-1:0] inc,
                          input int cnt, input bit gaps);
    logic [DW-1:0] d;
    d = first;
    for (int k = 0; k < cnt; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        step();
      end
      send(d);
      d = d + inc;
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic ack_pulse();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_weights", 64'(weights), 64'(0));
    chk("reset_inputs", 64'(inputs), 64'(0));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    step();

    // contiguous load
    send_run(8'h11, 8'h11, 8, 1'b0);
    @(negedge clk);
    chk("t1_weights", 64'(weights), 64'h44332211);
    chk("t1_inputs", 64'(inputs), 64'h88776655);
    chk("t1_out_valid", 64'(out_valid), 64'(1));
    chk("t1_load_idx", 64'(load_idx), 64'(0));
    chk("t1_in_ready", 64'(in_ready), 64'(CAP > 1));
    step();
    ack_pulse();
    step();

    // backpressure: valid every other cycle
    send_run(8'h11, 8'h11, 8, 1'b1);
    @(negedge clk);
    chk("t2_weights", 64'(weights), 64'h44332211);
    chk("t2_inputs", 64'(inputs), 64'h88776655);
    step();
    ack_pulse();
    step();

    // flush after 3 beats, with a beat offered in the flush cycle
    send_run(8'hA1, 8'h01, 3, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t3_load_idx_flush", 64'(load_idx), 64'(0));
    step();
    send_run(8'h01, 8'h01, 8, 1'b0);
    @(negedge clk);
    chk("t3_weights", 64'(weights), 64'h04030201);
    chk("t3_inputs", 64'(inputs), 64'h08070605);
    step();
    ack_pulse();
    step();

    // reset mid-frame
    send_run(8'h31, 8'h01, 5, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_weights", 64'(weights), 64'(0));
    chk("t4_inputs", 64'(inputs), 64'(0));
    chk("t4_out_valid", 64'(out_valid), 64'(0));
    chk("t4_load_idx", 64'(load_idx), 64'(0));
    step();
    send_run(8'h11, 8'h11, 8, 1'b0);
    @(negedge clk);
    chk("t4_reload_weights", 64'(weights), 64'h44332211);
    chk("t4_reload_inputs", 64'(inputs), 64'h88776655);
    step();
    ack_pulse();
    step();

`ifdef OPERAND_BUFFER_PINGPONG_EN
    // A then B without ack
    send_run(8'h11, 8'h11, 8, 1'b0);
    send_run(8'hA1, 8'h01, 8, 1'b0);
    @(negedge clk);
    chk("pp1_in_ready", 64'(in_ready), 64'(0));
    chk("pp1_weights_a", 64'(weights), 64'h44332211);
    step();
    ack_pulse();
    @(negedge clk);
    chk("pp1_weights_b", 64'(weights), 64'hA4A3A2A1);
    chk("pp1_inputs_b", 64'(inputs), 64'hA8A7A6A5);
    chk("pp1_out_valid", 64'(out_valid), 64'(1));
    chk("pp1_in_ready", 64'(in_ready), 64'(1));
    step();
    ack_pulse();
    step();

    // last beat of B together with ack of A
    send_run(8'h11, 8'h11, 8, 1'b0);
    send_run(8'hA1, 8'h01, 7, 1'b0);
    out_ack = 1'b1;
    send(8'hA8);
    in_valid = 1'b0;
    out_ack  = 1'b0;
    @(negedge clk);
    chk("pp2_weights_b", 64'(weights), 64'hA4A3A2A1);
    chk("pp2_inputs_b", 64'(inputs), 64'hA8A7A6A5);
    chk("pp2_out_valid", 64'(out_valid), 64'(1));
    chk("pp2_load_idx", 64'(load_idx), 64'(0));
    step();
    ack_pulse();
    step();
`endif

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = DW'($urandom);
      flush    = ($urandom_range(0, 49) == 0);
      out_ack  = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ack = 1'b1;
    repeat (4) step();
    out_ack = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
